wired_lsu_sb_drain: RTL and testbench

WIRED_LSU_SB_DRAIN -- requirements
Module: wired_lsu_sb_drain

---
 rtl/wired_lsu_sb_drain.sv | 187 ++++++++++++++++++
 tb/tb_wired_lsu_sb_drain.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_lsu_sb_drain.sv
// -----------------------------------------------------------------------------
// wired_lsu_sb_drain
//
// Drains committed stores from the top of the store buffer into the dcache
// data SRAM. It tracks how many stores have committed but are not yet written.
// A top entry that hits is written through the data-SRAM port. Each accepted
// write pops the entry and is broadcast on the snoop port. A top entry that
// misses first goes through the refill handshake. The hit is then checked
// again.
//
// Optional feature macro: WIRED_SB_DRAIN_PERF_EN
//   defined   -> 16-bit saturating perf counters (drains, misses)
//   undefined -> perf outputs tied to 0, no counter registers
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   commit_i           one pulse per committed store
//   sb_valid_i         store-buffer top entry present
//   sb_hit_i           top-entry way hit (one-hot, WAY_N bits)
//   sb_addr_i/data_i/strb_i  top-entry payload
//   sb_pop_o           invalidate the store-buffer top entry
//   dsram_req_o/ready_i      data-SRAM write handshake
//   dsram_addr_o/data_o/strb_o/way_o  data-SRAM write payload
//   snoop_valid_o/addr_o/data_o/strb_o/way_o  write broadcast to SB entries
//   refill_req_o/ack_i/done_i, refill_addr_o  miss handshake (line address)
//   busy_o             committed store outstanding or operation in flight
//   perf_drain_o, perf_miss_o  performance counters
// -----------------------------------------------------------------------------
module wired_lsu_sb_drain #(
  parameter int ADDR_W = 32,
  parameter int WAY_N  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_i,
  input  logic              sb_valid_i,
  input  logic [WAY_N-1:0]  sb_hit_i,
  input  logic [ADDR_W-1:0] sb_addr_i,
  input  logic [31:0]       sb_data_i,
  input  logic [3:0]        sb_strb_i,
  output logic              sb_pop_o,
  output logic              dsram_req_o,
  input  logic              dsram_ready_i,
  output logic [ADDR_W-1:0] dsram_addr_o,
  output logic [31:0]       dsram_data_o,
  output logic [3:0]        dsram_strb_o,
  output logic [WAY_N-1:0]  dsram_way_o,
  output logic              snoop_valid_o,
  output logic [ADDR_W-1:0] snoop_addr_o,
  output logic [31:0]       snoop_data_o,
  output logic [3:0]        snoop_strb_o,
  output logic [WAY_N-1:0]  snoop_way_o,
  output logic              refill_req_o,
  input  logic              refill_ack_i,
  input  logic              refill_done_i,
  output logic [ADDR_W-1:0] refill_addr_o,
  output logic              busy_o,
  output logic [15:0]       perf_drain_o,
  output logic [15:0]       perf_miss_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_MISS_REQ  = 2'd2,
    S_MISS_WAIT = 2'd3
  } state_t;

  state_t            r_state;
  logic [2:0]        r_cmt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [3:0]        r_strb;
  logic [WAY_N-1:0]  r_way;

  logic w_accept;
  logic w_start;
  logic w_hit;
  logic w_miss_start;

  // An entry may only leave IDLE once a commit covers it. This keeps
  // speculative entries out of the SRAM.
  assign w_start      = (r_cmt != 3'd0) && sb_valid_i;
  assign w_hit        = |sb_hit_i;
  assign w_miss_start = (r_state == S_IDLE) && w_start && !w_hit;

  // dsram_ready_i only matters while a request is actually presented.
  assign w_accept = (r_state == S_WRITE) && dsram_ready_i;

  // Commit counter: saturates at 4. A commit and an accept in the same cycle
  // cancel each other.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_cmt <= 3'd0;
    end else if (commit_i && !w_accept && (r_cmt != 3'd4)) begin
      r_cmt <= r_cmt + 3'd1;
    end else if (!commit_i && w_accept) begin
      r_cmt <= r_cmt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload registers are reset on purpose. They drive output
    // ports directly, and every output must read 0 while reset is held.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_way   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr <= sb_addr_i;
            if (w_hit) begin
              r_data  <= sb_data_i;
              r_strb  <= sb_strb_i;
              r_way   <= sb_hit_i;
              r_state <= S_WRITE;
            end else begin
              r_state <= S_MISS_REQ;
            end
          end
        end
        S_WRITE: begin
          if (dsram_ready_i) r_state <= S_IDLE;
        end
        S_MISS_REQ: begin
          if (refill_ack_i) r_state <= S_MISS_WAIT;
        end
        S_MISS_WAIT: begin
          // Back to IDLE rather than straight to WRITE. The hit vector after
          // the refill is the one that decides the way.
          if (refill_done_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dsram_req_o  = (r_state == S_WRITE);
  assign dsram_addr_o = r_addr;
  assign dsram_data_o = r_data;
  assign dsram_strb_o = r_strb;
  assign dsram_way_o  = r_way;

  // Pop and snoop mark the accept cycle itself. A store buffer that observes
  // the snoop then sees exactly the data that was written.
  assign sb_pop_o      = w_accept;
  assign snoop_valid_o = w_accept;
  assign snoop_addr_o  = r_addr;
  assign snoop_data_o  = r_data;
  assign snoop_strb_o  = r_strb;
  assign snoop_way_o   = r_way;

  assign refill_req_o  = (r_state == S_MISS_REQ);
  assign refill_addr_o = {r_addr[ADDR_W-1:4], 4'b0000};

  assign busy_o = (r_cmt != 3'd0) || (r_state != S_IDLE);

`ifdef WIRED_SB_DRAIN_PERF_EN
  logic [15:0] r_perf_drain;
  logic [15:0] r_perf_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_drain <= 16'd0;
      r_perf_miss  <= 16'd0;
    end else begin
      if (w_accept && (r_perf_drain != 16'hFFFF)) r_perf_drain <= r_perf_drain + 16'd1;
      if (w_miss_start && (r_perf_miss != 16'hFFFF)) r_perf_miss <= r_perf_miss + 16'd1;
    end
  end

  assign perf_drain_o = r_perf_drain;
  assign perf_miss_o  = r_perf_miss;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_miss_start;
  assign perf_drain_o  = 16'd0;
  assign perf_miss_o   = 16'd0;
`endif

endmodule

// File: tb/tb_wired_lsu_sb_drain.sv
// -----------------------------------------------------------------------------
// tb_wired_lsu_sb_drain
//
// Directed bench for wired_lsu_sb_drain. Inputs change 1 time unit after the
// rising edge, and outputs are sampled on the falling edge. Expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_wired_lsu_sb_drain;

  localparam int ADDR_W = 32;
  localparam int WAY_N  = 2;

`ifdef WIRED_SB_DRAIN_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              commit_i;
  logic              sb_valid_i;
  logic [WAY_N-1:0]  sb_hit_i;
  logic [ADDR_W-1:0] sb_addr_i;
  logic [31:0]       sb_data_i;
  logic [3:0]        sb_strb_i;
  logic              sb_pop_o;
  logic              dsram_req_o;
  logic              dsram_ready_i;
  logic [ADDR_W-1:0] dsram_addr_o;
  logic [31:0]       dsram_data_o;
  logic [3:0]        dsram_strb_o;
  logic [WAY_N-1:0]  dsram_way_o;
  logic              snoop_valid_o;
  logic [ADDR_W-1:0] snoop_addr_o;
  logic [31:0]       snoop_data_o;
  logic [3:0]        snoop_strb_o;
  logic [WAY_N-1:0]  snoop_way_o;
  logic              refill_req_o;
  logic              refill_ack_i;
  logic              refill_done_i;
  logic [ADDR_W-1:0] refill_addr_o;
  logic              busy_o;
  logic [15:0]       perf_drain_o;
  logic [15:0]       perf_miss_o;

  wired_lsu_sb_drain #(.ADDR_W(ADDR_W), .WAY_N(WAY_N)) dut (
    .clk(clk), .rst_n(rst_n), .commit_i(commit_i),
    .sb_valid_i(sb_valid_i), .sb_hit_i(sb_hit_i), .sb_addr_i(sb_addr_i),
    .sb_data_i(sb_data_i), .sb_strb_i(sb_strb_i), .sb_pop_o(sb_pop_o),
    .dsram_req_o(dsram_req_o), .dsram_ready_i(dsram_ready_i),
    .dsram_addr_o(dsram_addr_o), .dsram_data_o(dsram_data_o),
    .dsram_strb_o(dsram_strb_o), .dsram_way_o(dsram_way_o),
    .snoop_valid_o(snoop_valid_o), .snoop_addr_o(snoop_addr_o),
    .snoop_data_o(snoop_data_o), .snoop_strb_o(snoop_strb_o),
    .snoop_way_o(snoop_way_o), .refill_req_o(refill_req_o),
    .refill_ack_i(refill_ack_i), .refill_done_i(refill_done_i),
    .refill_addr_o(refill_addr_o), .busy_o(busy_o),
    .perf_drain_o(perf_drain_o), .perf_miss_o(perf_miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_total = 0;

  // Free-running pop counter. Tests compare the difference across a window.
  always @(negedge clk) if (sb_pop_o === 1'b1) pop_total <= pop_total + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, {63'd0, |{sb_pop_o, dsram_req_o, dsram_addr_o, dsram_data_o, dsram_strb_o,
                         dsram_way_o, snoop_valid_o, snoop_addr_o, snoop_data_o,
                         snoop_strb_o, snoop_way_o, refill_req_o, refill_addr_o,
                         busy_o, perf_drain_o, perf_miss_o}}, 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    commit_i      = 1'b0;
    sb_valid_i    = 1'b0;
    sb_hit_i      = '0;
    sb_addr_i     = '0;
    sb_data_i     = '0;
    sb_strb_i     = '0;
    dsram_ready_i = 1'b0;
    refill_ack_i  = 1'b0;
    refill_done_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic load_entry(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] h);
    sb_valid_i = 1'b1;
    sb_addr_i  = a;
    sb_data_i  = d;
    sb_strb_i  = s;
    sb_hit_i   = h;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int timeouts;

    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_outs_zero("reset_outputs_zero");
    repeat (2) step();
    rst_n = 1'b1;

    // ---- Hit store, commit at cycle 0, ready tied high ----
    do_reset();
    load_entry(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 2'b01);
    dsram_ready_i = 1'b1;
    commit_i = 1'b1;                                   // cycle 0
    @(negedge clk);
    check("hit_c0_req", {63'd0, dsram_req_o}, 64'd0);
    step(); commit_i = 1'b0;                           // cycle 1
    @(negedge clk);
    check("hit_c1_req", {63'd0, dsram_req_o}, 64'd0);
    check("hit_c1_busy", {63'd0, busy_o}, 64'd1);
    step();                                            // cycle 2
    @(negedge clk);
    check("hit_c2_req", {63'd0, dsram_req_o}, 64'd1);
    check("hit_c2_pop", {63'd0, sb_pop_o}, 64'd1);
    check("hit_c2_snoop", {63'd0, snoop_valid_o}, 64'd1);
    check("hit_c2_way", {62'd0, dsram_way_o}, 64'd1);
    check("hit_c2_addr", {32'd0, dsram_addr_o}, 64'h1000_0004);
    check("hit_c2_data", {32'd0, dsram_data_o}, 64'hDEAD_BEEF);
    check("hit_c2_strb", {60'd0, dsram_strb_o}, 64'hF);
    check("hit_c2_snoop_addr", {32'd0, snoop_addr_o}, 64'h1000_0004);
    check("hit_c2_snoop_data", {32'd0, snoop_data_o}, 64'hDEAD_BEEF);
    check("hit_c2_snoop_way", {62'd0, snoop_way_o}, 64'd1);
    step(); sb_valid_i = 1'b0;                         // cycle 3
    @(negedge clk);
    check("hit_c3_busy", {63'd0, busy_o}, 64'd0);
    check("hit_c3_pop", {63'd0, sb_pop_o}, 64'd0);
    check("hit_perf_drain", {48'd0, perf_drain_o}, PERF_EN ? 64'd1 : 64'd0);

    // ---- Five back-to-back commits with SRAM stalled: saturation at 4 ----
    do_reset();
    load_entry(32'h0000_0050, 32'h0102_0304, 4'h3, 2'b01);
    base = pop_total;
    for (int i = 0; i < 5; i++) begin
      commit_i = 1'b1;
      step();
    end
    commit_i = 1'b0;
    dsram_ready_i = 1'b1;
    repeat (20) step();
    check("sat_pop_count", 64'(pop_total - base), 64'd4);
    check("sat_busy_end", {63'd0, busy_o}, 64'd0);
    check("sat_perf_drain", {48'd0, perf_drain_o}, PERF_EN ? 64'd4 : 64'd0);

    // ---- Miss, refill handshake, then hit in way 1 ----
    do_reset();
    load_entry(32'h2000_0038, 32'h1234_5678, 4'h3, 2'b00);
    dsram_ready_i = 1'b1;
    commit_i = 1'b1;                                   // cycle 0
    step(); commit_i = 1'b0;                           // cycle 1
    @(negedge clk);
    check("miss_c1_refill_req", {63'd0, refill_req_o}, 64'd0);
    step();                                            // cycle 2
    @(negedge clk);
    check("miss_c2_refill_req", {63'd0, refill_req_o}, 64'd1);
    check("miss_c2_refill_addr", {32'd0, refill_addr_o}, 64'h2000_0030);
    check("miss_c2_dsram_req", {63'd0, dsram_req_o}, 64'd0);
    step(); refill_ack_i = 1'b1;                       // cycle 3
    @(negedge clk);
    check("miss_c3_refill_req_hold", {63'd0, refill_req_o}, 64'd1);
    step();                                            // cycle 4: MISS_WAIT
    refill_ack_i = 1'b0; refill_done_i = 1'b1; sb_hit_i = 2'b10;
    @(negedge clk);
    check("miss_c4_refill_req", {63'd0, refill_req_o}, 64'd0);
    check("miss_c4_busy", {63'd0, busy_o}, 64'd1);
    step(); refill_done_i = 1'b0;                      // cycle 5: IDLE
    @(negedge clk);
    check("miss_c5_req", {63'd0, dsram_req_o}, 64'd0);
    step();                                            // cycle 6: WRITE
    @(negedge clk);
    check("miss_c6_req", {63'd0, dsram_req_o}, 64'd1);
    check("miss_c6_pop", {63'd0, sb_pop_o}, 64'd1);
    check("miss_c6_way", {62'd0, dsram_way_o}, 64'd2);
    check("miss_c6_addr", {32'd0, dsram_addr_o}, 64'h2000_0038);
    check("miss_perf_miss", {48'd0, perf_miss_o}, PERF_EN ? 64'd1 : 64'd0);
    step(); sb_valid_i = 1'b0;
    @(negedge clk);
    check("miss_c7_busy", {63'd0, busy_o}, 64'd0);

    // ---- SRAM stall for 5 cycles, accept together with a new commit ----
    do_reset();
    load_entry(32'h3000_0008, 32'hA5A5_0F0F, 4'h6, 2'b01);
    base = pop_total;
    commit_i = 1'b1;                                   // cycle 0
    step(); commit_i = 1'b0;                           // cycle 1
    step();                                            // cycle 2: WRITE
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        sb_addr_i = 32'hFFFF_FFF0;
        sb_data_i = 32'h0000_0000;
        sb_strb_i = 4'h1;
        sb_hit_i  = 2'b10;
      end
      @(negedge clk);
      check($sformatf("stall%0d_req", i), {63'd0, dsram_req_o}, 64'd1);
      check($sformatf("stall%0d_pop", i), {63'd0, sb_pop_o}, 64'd0);
      check($sformatf("stall%0d_addr", i), {32'd0, dsram_addr_o}, 64'h3000_0008);
      check($sformatf("stall%0d_data", i), {32'd0, dsram_data_o}, 64'hA5A5_0F0F);
      check($sformatf("stall%0d_strb_way", i), {58'd0, dsram_strb_o, dsram_way_o}, {58'd0, 4'h6, 2'b01});
      step();
    end
    load_entry(32'h3000_0008, 32'hA5A5_0F0F, 4'h6, 2'b01);
    dsram_ready_i = 1'b1; commit_i = 1'b1;             // cycle 7: accept + commit
    @(negedge clk);
    check("stall_accept_pop", {63'd0, sb_pop_o}, 64'd1);
    check("stall_accept_data", {32'd0, snoop_data_o}, 64'hA5A5_0F0F);
    step(); commit_i = 1'b0;                           // cycle 8: IDLE
    @(negedge clk);
    check("stall_c8_pop", {63'd0, sb_pop_o}, 64'd0);
    step();                                            // cycle 9: second write
    @(negedge clk);
    check("stall_c9_pop", {63'd0, sb_pop_o}, 64'd1);
    step(); sb_valid_i = 1'b0;                         // cycle 10
    @(negedge clk);
    check("stall_c10_busy", {63'd0, busy_o}, 64'd0);
    step();
    check("stall_pop_count", 64'(pop_total - base), 64'd2);

    // ---- Reset asserted in MISS_WAIT ----
    do_reset();
    load_entry(32'h4000_0014, 32'h5555_AAAA, 4'hC, 2'b00);
    dsram_ready_i = 1'b1;
    commit_i = 1'b1;                                   // cycle 0
    step(); commit_i = 1'b0;                           // cycle 1
    step(); refill_ack_i = 1'b1;                       // cycle 2: MISS_REQ
    @(negedge clk);
    check("rstmiss_refill_req", {63'd0, refill_req_o}, 64'd1);
    step(); refill_ack_i = 1'b0;                       // cycle 3: MISS_WAIT
    @(negedge clk);
    check("rstmiss_wait_busy", {63'd0, busy_o}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_outs_zero("rstmiss_outputs_zero");
    step();
    step();
    rst_n = 1'b1;
    sb_hit_i = 2'b01;
    refill_done_i = 1'b1;                              // stray done in IDLE
    base = pop_total;
    step(); refill_done_i = 1'b0;
    repeat (6) step();
    check("rstmiss_no_pop", 64'(pop_total - base), 64'd0);
    check("rstmiss_busy", {63'd0, busy_o}, 64'd0);
    check("rstmiss_req", {63'd0, dsram_req_o}, 64'd0);

    // ---- Ten separate drains ----
    do_reset();
    load_entry(32'h0000_1100, 32'hCAFE_F00D, 4'hF, 2'b01);
    dsram_ready_i = 1'b1;
    base = pop_total;
    timeouts = 0;
    for (int k = 0; k < 10; k++) begin
      commit_i = 1'b1;
      step();
      commit_i = 1'b0;
      for (int w = 0; w < 8 && busy_o; w++) step();
      if (busy_o) timeouts++;
    end
    check("drain10_timeouts", 64'(timeouts), 64'd0);
    check("drain10_pop_count", 64'(pop_total - base), 64'd10);
    check("drain10_perf_drain", {48'd0, perf_drain_o}, PERF_EN ? 64'd10 : 64'd0);
    check("drain10_perf_miss", {48'd0, perf_miss_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
